// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding and FSM states.
package muldiv_hilo_unit_pkg;

    // op[1] selects divide, op[0] selects unsigned.
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        ZERO
    } state_t;

    // Signed ops are the even encodings.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_div_iter_core.sv
// Restoring shift-subtract divider on unsigned magnitudes, one quotient bit
// per step. The dividend is shifted out of the quotient register as quotient
// bits are shifted in.
module muldiv_hilo_unit_div_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;
    logic             unused_diff_bit;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        diff  = {1'b0, trial} - {2'b00, divisor};
    end

    // diff[WIDTH] is always 0 when the subtraction succeeds (remainder < divisor).
    assign unused_diff_bit = diff[WIDTH];

    // Iteration registers: load seeds the operands, each step retires one bit.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt <= '0;
            quo <= '0;
            rem <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            cnt <= CNT_W'(WIDTH);
        end else if (step) begin
            rem <= diff[WIDTH+1] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH+1]};
            cnt <= cnt - 1'b1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign last      = (cnt == CNT_W'(1));

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Signed operands are captured as magnitude + sign; results are sign-fixed on
// write-back. The product is formed from the held magnitudes and written after
// MUL_LAT busy cycles, leaving synthesis free to retime the multiplier.
module muldiv_hilo_unit
    import muldiv_hilo_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic [MCNT_W-1:0]   mul_cnt;

    logic                neg_a_d;
    logic                neg_b_d;
    logic [WIDTH-1:0]    mag_a_d;
    logic [WIDTH-1:0]    mag_b_d;

    logic                neg_a;
    logic                neg_q;
    logic [WIDTH-1:0]    mag_a;
    logic [WIDTH-1:0]    mag_b;

    logic                div_load;
    logic                div_step;
    logic                wr_mul;
    logic                wr_fix;
    logic                wr_zero;

    logic [WIDTH-1:0]    quo;
    logic [WIDTH-1:0]    rem;
    logic                div_last;

    logic [2*WIDTH-1:0]  prod_mag;
    logic [2*WIDTH-1:0]  prod;
    logic [WIDTH-1:0]    quo_fixed;
    logic [WIDTH-1:0]    rem_fixed;
    logic [WIDTH-1:0]    a_orig;

    assign accept = (state == IDLE) && start && !flush;
    assign busy   = (state != IDLE);

    // Magnitude/sign split of the incoming operands; the most-negative value
    // maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    always_comb begin
        neg_a_d = is_signed_op(op) & a[WIDTH-1];
        neg_b_d = is_signed_op(op) & b[WIDTH-1];
        mag_a_d = neg_a_d ? -a : a;
        mag_b_d = neg_b_d ? -b : b;
    end

    muldiv_hilo_unit_div_iter_core #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a_d),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem),
        .last      (div_last)
    );

    // Signed results: product and quotient take sign(a)^sign(b), remainder takes sign(a).
    always_comb begin
        prod_mag  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
        prod      = neg_q ? -prod_mag : prod_mag;
        quo_fixed = neg_q ? -quo : quo;
        rem_fixed = neg_a ? -rem : rem;
        a_orig    = neg_a ? -mag_a : mag_a;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic; flush forces IDLE from any state.
    always_comb begin
        // NOTE: default assignment first so no path leaves the variable unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!op[1])         state_nxt = MUL;
                    else if (b == '0)   state_nxt = ZERO;
                    else                state_nxt = DIV;
                end
            end
            MUL:     if (mul_cnt == '0) state_nxt = IDLE;
            DIV:     if (div_last)      state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            ZERO:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // FSM outputs: divider control and result write strobes (suppressed by flush).
    always_comb begin
        div_load = accept && op[1];
        div_step = (state == DIV);
        wr_mul   = (state == MUL) && (mul_cnt == '0) && !flush;
        wr_fix   = (state == FIX) && !flush;
        wr_zero  = (state == ZERO) && !flush;
    end

    // Operand capture on accept and multiply latency countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt <= '0;
            neg_a   <= 1'b0;
            neg_q   <= 1'b0;
            mag_a   <= '0;
            mag_b   <= '0;
        end else if (accept) begin
            mag_a   <= mag_a_d;
            mag_b   <= mag_b_d;
            neg_a   <= neg_a_d;
            neg_q   <= neg_a_d ^ neg_b_d;
            mul_cnt <= MCNT_W'(MUL_LAT - 1);
        end else if ((state == MUL) && (mul_cnt != '0)) begin
            mul_cnt <= mul_cnt - 1'b1;
        end
    end

    // HI/LO write-back and the one-cycle done/div_zero pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= wr_mul | wr_fix | wr_zero;
            div_zero <= wr_zero;
            if (wr_mul) begin
                hi <= prod[2*WIDTH-1:WIDTH];
                lo <= prod[WIDTH-1:0];
            end else if (wr_fix) begin
                hi <= rem_fixed;
                lo <= quo_fixed;
            end else if (wr_zero) begin
                hi <= a_orig;
                lo <= '1;
            end
        end
    end

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Parametrised multi-cycle multiply/divide unit with its own HI/LO result registers. It sits in the execute stage of the 5-stage pipeline and replaces the single-width, ready-flag-only divide path. It accepts one operation per start handshake and reports progress through busy/done, which the hazard unit uses to stall. It supports signed and unsigned multiply and divide, an abort on pipeline flush, and defined divide-by-zero behaviour.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_LAT, 3, multiply latency in busy cycles; legal range ≥1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset: one clock, synchronous, active-high.
- start  in  1  request an operation; sampled only when busy=0.
- op  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- a  in  WIDTH  dividend or multiplicand; sampled on accept.
- b  in  WIDTH  divisor or multiplier; sampled on accept.
- flush  in  1  abort the operation in flight.
- busy  out  1  operation in flight; the hazard unit stalls E on busy=1.
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- div_zero  out  1  valid with done; 1 = the divide had b=0.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- FSM states:
  - IDLE: accepts start & ~flush. op[1]=0 → MUL; op[1]=1 and b≠0 → DIV; op[1]=1 and b=0 → ZERO.
  - MUL: down-counter loaded with MUL_LAT−1. Exit to IDLE and write hi/lo when the counter reaches 0.
  - DIV: restoring shift-subtract on magnitudes, one quotient bit per cycle, WIDTH iterations. Iteration counter is clog2(WIDTH+1) bits. Then go to FIX.
  - FIX: sign fixup, write hi/lo, go to IDLE.
  - ZERO: write lo=all ones, hi=a, set div_zero=1, go to IDLE.
- Operand capture on accept:
  - Signed ops store |a|, |b| and the sign flags.
  - The magnitude of the most-negative value is 2^(WIDTH−1), held unsigned; the datapath is WIDTH+1 bits internally.
- Arithmetic:
  - Multiply result is the full 2·WIDTH-bit product: hi = upper half, lo = lower half.
  - Signed divide truncates toward zero. Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
  - Signed overflow (most-negative / −1): lo = most-negative, hi = 0, no flag.
- busy = (state≠IDLE).
- done and div_zero are registered. They are asserted for exactly one cycle, the first cycle back in IDLE.
- start while busy=1 is ignored; no queueing.
- A new start is accepted in the done cycle, so operations can run back to back.
- flush:
  - With busy=1: state goes to IDLE on the next edge; hi, lo and done are not updated.
  - In IDLE: a concurrent start is dropped.
  - flush does not retract a done already asserted; the pipeline masks it.
- hi/lo change only on completion; otherwise they hold.
- Reset: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counters=0. Reset mid-operation discards the operation.

## Timing
- The accept edge is cycle 0.
- MULT/MULTU: busy=1 in cycles 1..MUL_LAT; done=1 in cycle MUL_LAT+1.
- DIV/DIVU, b≠0: busy=1 in cycles 1..WIDTH+1 (WIDTH iterations, then FIX); done=1 in cycle WIDTH+2.
- Divide by zero: busy=1 in cycle 1; done=1 and div_zero=1 in cycle 2.
- busy=0 in the done cycle.
- flush seen in cycle k (busy=1): busy=0 and done=0 in cycle k+1.

## Structure
- Shared package holds:
  - the op encoding constants MULT/MULTU/DIV/DIVU;
  - the FSM state enum (IDLE, MUL, DIV, FIX, ZERO).
- One natural sub-module, div_iter_core:
  - magnitude shift-subtract datapath with iteration counter;
  - ports: load, step, quotient/remainder out.
- The multiply path is a behavioural product plus a MUL_LAT-deep result delay. Synthesis retimes it.

## Test plan
- MULT, WIDTH=32: a=−3, b=7 → done at cycle 4 (MUL_LAT=3), hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU with a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV signed: a=−7, b=2 → done at cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU: a=100, b=7 → lo=14, hi=2. busy high cycles 1..33.
- Divide by zero: DIVU a=0x1234, b=0 → done and div_zero at cycle 2, lo=0xFFFFFFFF, hi=0x1234. Signed overflow: 0x80000000 / −1 → lo=0x80000000, hi=0, div_zero=0.
- Flush at cycle 10 of a DIV → busy=0 at cycle 11, no done pulse, hi/lo keep their previous values. Repeat with rst instead of flush → all outputs 0.
- start held high while busy with different operands → ignored, and the first result is intact. A start in the done cycle is accepted, and its result lands MUL_LAT+1 cycles later.
- start and flush together in IDLE → nothing accepted, busy stays 0. Sweep MUL_LAT=1 and WIDTH=8 against a reference model on random operands.
